// File: rtl/alpharetz_sb_regfile_if.sv
// Bus bundle for the scoreboarded register file: writeback, claim and read ports.
// The master modport is the pipeline side and the slave modport is the register file.
interface alpharetz_sb_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int RD_PORTS   = 2
);
   localparam int AW = $clog2(REG_COUNT);
   localparam int CW = $clog2(REG_COUNT + 1);

   logic                           wr_en;
   logic [AW-1:0]                  wr_addr;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic                           claim_en;
   logic [AW-1:0]                  claim_addr;
   logic                           claim_ok;
   logic [RD_PORTS-1:0]            rd_en;
   logic [RD_PORTS*AW-1:0]         rd_addr;
   logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic [RD_PORTS-1:0]            rd_busy;
   logic [CW-1:0]                  busy_count;

   modport master (
      output wr_en, wr_addr, wr_data, claim_en, claim_addr, rd_en, rd_addr,
      input  claim_ok, rd_data, rd_busy, busy_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, claim_en, claim_addr, rd_en, rd_addr,
      output claim_ok, rd_data, rd_busy, busy_count
   );
endinterface

// File: rtl/alpharetz_sb_regfile.sv
// Register file with a per-register busy scoreboard; r0 is hardwired to zero and never busy.
// Define ALPHARETZ_RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module alpharetz_sb_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int RD_PORTS   = 2
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  clk_en,
   input  logic                  sys_en,
   alpharetz_sb_regfile_if.slave bus
);
   localparam int AW = $clog2(REG_COUNT);
   localparam int CW = $clog2(REG_COUNT + 1);

   logic [DATA_WIDTH-1:0]          regs_r [REG_COUNT];
   logic [REG_COUNT-1:0]           busy_r;
   logic [CW-1:0]                  busy_count_r;

   logic                           en_s;
   logic                           wr_commit_s;
   logic                           wr_hits_claim_s;
   logic                           claim_ok_s;
   logic                           claim_set_s;
   logic                           busy_set_s;
   logic                           busy_clr_s;
   logic [REG_COUNT-1:0]           busy_next_s;
   logic [CW-1:0]                  busy_count_next_s;
   logic [AW-1:0]                  port_addr_s [RD_PORTS];
   logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_s;
   logic [RD_PORTS-1:0]            rd_busy_s;

   assign en_s            = clk_en & sys_en;
   assign wr_commit_s     = en_s & bus.wr_en & (bus.wr_addr != '0);
   assign wr_hits_claim_s = en_s & bus.wr_en & (bus.wr_addr == bus.claim_addr);
   assign claim_ok_s      = bus.claim_en & ((bus.claim_addr == '0) | ~busy_r[bus.claim_addr] | wr_hits_claim_s);
   assign claim_set_s     = claim_ok_s & en_s & (bus.claim_addr != '0);

   // Real 0->1 / 1->0 transitions; a claim landing on the written register keeps it busy.
   assign busy_set_s = claim_set_s & ~busy_r[bus.claim_addr];
   assign busy_clr_s = wr_commit_s & busy_r[bus.wr_addr] &
                       ~(claim_set_s & (bus.claim_addr == bus.wr_addr));

   assign busy_count_next_s = busy_count_r + CW'(busy_set_s) - CW'(busy_clr_s);

   // Next scoreboard state: writeback clears first, then an accepted claim sets.
   always_comb begin
      busy_next_s = busy_r;
      if (wr_commit_s) begin
         busy_next_s[bus.wr_addr] = 1'b0;
      end else begin
         busy_next_s[bus.wr_addr] = busy_r[bus.wr_addr];
      end
      if (claim_set_s) begin
         busy_next_s[bus.claim_addr] = 1'b1;
      end else begin
         busy_next_s[bus.claim_addr] = busy_next_s[bus.claim_addr];
      end
   end

   for (genvar g = 0; g < RD_PORTS; g++) begin : g_port_addr
      assign port_addr_s[g] = bus.rd_addr[g*AW +: AW];
   end

   // Zero-latency read ports; disabled ports and r0 return zero and not-busy.
   always_comb begin
      rd_data_s = '0;
      rd_busy_s = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         if (!bus.rd_en[p]) begin
            rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_busy_s[p]                          = 1'b0;
`ifdef ALPHARETZ_RF_BYPASS_EN
         end else if (wr_commit_s && (port_addr_s[p] == bus.wr_addr)) begin
            rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
            rd_busy_s[p]                          = 1'b0;
`endif
         end else if (port_addr_s[p] == '0) begin
            rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_busy_s[p]                          = 1'b0;
         end else begin
            rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = regs_r[port_addr_s[p]];
            rd_busy_s[p]                          = busy_r[port_addr_s[p]];
         end
      end
   end

   // Architectural state update; reset overrides any write or claim in the same cycle.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_r[i] <= '0;
         end
         busy_r       <= '0;
         busy_count_r <= '0;
      end else begin
         if (wr_commit_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
         end
         busy_r       <= busy_next_s;
         busy_count_r <= busy_count_next_s;
      end
   end

   assign bus.claim_ok   = claim_ok_s;
   assign bus.rd_data    = rd_data_s;
   assign bus.rd_busy    = rd_busy_s;
   assign bus.busy_count = busy_count_r;
endmodule

// File: doc/alpharetz_sb_regfile.md
ALPHARETZ_SB_REGFILE -- requirements
Module: alpharetz_sb_regfile

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, register width in bits.
- REQ-002: Parameter REG_COUNT, default 32, number of architectural registers; power of two, >= 2.
- REQ-003: Parameter RD_PORTS, default 2, number of independent read ports, >= 1; AW = $clog2(REG_COUNT), CW = $clog2(REG_COUNT+1).
- REQ-004: clk  in  1  single clock, all state updates on rising edge.
- REQ-005: sync_rst  in  1  reset, synchronous, active-high.
- REQ-006: clk_en  in  1  clock qualifier; sys_en  in  1  system enable; effective enable en = clk_en && sys_en.
- REQ-007: wr_en  in  1; wr_addr  in  AW; wr_data  in  DATA_WIDTH  writeback port; also clears busy bit of wr_addr.
- REQ-008: claim_en  in  1; claim_addr  in  AW  request to mark a destination register busy.
- REQ-009: claim_ok  out  1  combinational grant for current claim request.
- REQ-010: rd_en  in  RD_PORTS; rd_addr  in  RD_PORTS*AW; rd_data  out  RD_PORTS*DATA_WIDTH; rd_busy  out  RD_PORTS  per-port read, port p in slice p.
- REQ-011: busy_count  out  CW  number of registers currently busy.

Function
- REQ-012: Register 0 reads as 0, never written, never busy; claim to address 0 SHALL give claim_ok=1 with no state change.
- REQ-013: Write commits wr_data into register wr_addr at the edge when en && wr_en && wr_addr!=0.
- REQ-014: Reads combinational, zero latency; rd_en[p]=0 -> rd_data[p]=0, rd_busy[p]=0; otherwise rd_data[p]=stored value, rd_busy[p]=busy[rd_addr[p]] (subject to REQ-024).
- REQ-015: Busy bit state per register: IDLE(0) -> BUSY(1) on accepted claim; BUSY -> IDLE on committed write to that address.
- REQ-016: claim_ok = claim_en && (claim_addr==0 || !busy[claim_addr] || (en && wr_en && wr_addr==claim_addr)); claim_ok SHALL be 0 when claim_en=0.
- REQ-017: Accepted claim (claim_ok && en && claim_addr!=0) SHALL set busy at the edge.
- REQ-018: Simultaneous write and accepted claim to same nonzero address: data committed, busy ends 1 (claim wins).
- REQ-019: Claim refused on a busy register with no matching write: no state change, requester retries.
- REQ-020: Write to a non-busy register SHALL commit data and leave busy=0.
- REQ-021: busy_count SHALL be registered, next value = current + (set?1:0) - (clear?1:0), where set/clear are actual 0->1 / 1->0 transitions; never wraps, range 0..REG_COUNT-1.
- REQ-022: en=0: no writes, no claims commit, busy_count holds; reads still operate; claim_ok still reflects REQ-016 with write term gated by en.

Reset
- REQ-023: sync_rst=1 at an edge SHALL clear all registers to 0, all busy bits to 0, busy_count to 0, regardless of en, wr_en, claim_en; reset wins over any simultaneous write or claim, and outputs after that edge SHALL read 0.

Configuration
- REQ-024: Macro ALPHARETZ_RF_BYPASS_EN defined: read port p with rd_en[p], rd_addr[p]==wr_addr!=0, en && wr_en SHALL return wr_data and rd_busy[p]=0 same cycle; undefined: stored (pre-write) value and stored busy returned, new value visible the cycle after the edge.

Verification
- REQ-025: Reset, then read all addresses on all ports -> rd_data=0, rd_busy=0, busy_count=0.
- REQ-026: Claim r5 (claim_ok=1), next cycle claim r5 again -> claim_ok=0, busy_count=1; write 0xDEADBEEF to r5 -> next cycle rd_data=0xDEADBEEF, rd_busy=0, busy_count=0.
- REQ-027: r7 busy; same cycle write r7=0x1234 and claim r7 -> claim_ok=1, after edge r7=0x1234, rd_busy=1, busy_count=1.
- REQ-028: Write 0xFFFFFFFF to r0, claim r0 -> claim_ok=1, r0 reads 0, busy_count=0.
- REQ-029: Write r3=0x55 while port 1 reads r3 (old 0x0) -> with ALPHARETZ_RF_BYPASS_EN rd_data=0x55 same cycle; without, 0x0 then 0x55 next cycle.
- REQ-030: Claim r1..r31, then assert sync_rst with wr_en and claim_en high -> all busy cleared, busy_count=0, all registers 0; with clk_en=0 a claim yields no busy change.
